nn_frame_loader: RTL and testbench

- Upstream stage of the digit-recognition network.
- Accepts a raster pixel stream over a valid/ready handshake and assembles a 28x28 frame in an internal buffer, exposed as a flat bus on the network's image input.
- Sequences the network: reset pulse, then enable held until done.
- Captures the recognised digit and returns to loading the next frame.

---
 rtl/nn_frame_loader.sv | 137 +++++++++++++
 tb/tb_nn_frame_loader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/nn_frame_loader.sv
// Loads a raster pixel stream into a 28x28 frame buffer, then sequences the network (reset, run) and captures its digit.
// Optional build macro NN_FRAME_BINARIZE_EN: store thresholded pixels (0 / 127) instead of pix_data >> 1.
module nn_frame_loader #(
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28,
    parameter int NN_RST_CYC  = 2,
    parameter int RUN_TIMEOUT = 200000,
    parameter int BIN_THRESH  = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               pix_data,
    input  logic                     pix_valid,
    input  logic                     pix_sof,
    output logic                     pix_ready,
    output logic [IMG_W*IMG_H*8-1:0] img_flat,
    output logic                     nn_reset,
    output logic                     nn_enable,
    input  logic                     nn_done,
    input  logic [7:0]               digit_in,
    output logic [7:0]               digit_out,
    output logic                     digit_valid,
    output logic                     timeout_err,
    output logic                     busy
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(NPIX);
    localparam int RST_W = (NN_RST_CYC > 1) ? $clog2(NN_RST_CYC) : 1;
    localparam int TO_W  = $clog2(RUN_TIMEOUT + 1);

    typedef enum logic [1:0] {S_LOAD, S_NN_RST, S_RUN} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [RST_W-1:0]   r_rst_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic [NPIX*8-1:0]  r_img;
    logic               r_pix_ready;
    logic               r_nn_reset;
    logic               r_nn_enable;
    logic [7:0]         r_digit_out;
    logic               r_digit_valid;
    logic               r_timeout_err;
    logic               r_busy;

    logic [7:0]         w_pix;
    logic [CNT_W-1:0]   w_idx;
    logic [CNT_W+2:0]   w_base;
    logic               w_accept;

`ifdef NN_FRAME_BINARIZE_EN
    localparam logic [7:0] BIN_T = 8'(BIN_THRESH);
    assign w_pix = (pix_data >= BIN_T) ? 8'd127 : 8'd0;
`else
    // Halving keeps the network's signed 8-bit read non-negative.
    logic w_unused;
    assign w_unused = ^{pix_data[0], 8'(BIN_THRESH)};
    assign w_pix    = {1'b0, pix_data[7:1]};
`endif

    assign w_accept = pix_valid & r_pix_ready;
    assign w_idx    = pix_sof ? '0 : r_cnt;
    assign w_base   = {w_idx, 3'b000};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_LOAD;
            r_cnt         <= '0;
            r_rst_cnt     <= '0;
            r_to_cnt      <= '0;
            r_img         <= '0;
            r_pix_ready   <= 1'b1;
            r_nn_reset    <= 1'b1;
            r_nn_enable   <= 1'b0;
            r_digit_out   <= '0;
            r_digit_valid <= 1'b0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_digit_valid <= 1'b0;
            unique case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        r_img[w_base +: 8] <= w_pix;
                        if (pix_sof) r_timeout_err <= 1'b0;
                        if (w_idx == CNT_W'(NPIX - 1)) begin
                            r_state     <= S_NN_RST;
                            r_cnt       <= '0;
                            r_rst_cnt   <= '0;
                            r_pix_ready <= 1'b0;
                            r_nn_reset  <= 1'b1;
                            r_busy      <= 1'b1;
                        end else begin
                            r_cnt <= w_idx + 1'b1;
                        end
                    end
                end
                S_NN_RST: begin
                    if (r_rst_cnt == RST_W'(NN_RST_CYC - 1)) begin
                        r_state     <= S_RUN;
                        r_nn_reset  <= 1'b0;
                        r_nn_enable <= 1'b1;
                        r_to_cnt    <= '0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    // nn_done takes priority over a timeout landing on the same edge.
                    if (nn_done || r_to_cnt == TO_W'(RUN_TIMEOUT - 1)) begin
                        r_state       <= S_LOAD;
                        r_pix_ready   <= 1'b1;
                        r_nn_enable   <= 1'b0;
                        r_busy        <= 1'b0;
                        r_digit_valid <= 1'b1;
                        r_digit_out   <= nn_done ? digit_in : 8'hFF;
                        if (!nn_done) r_timeout_err <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign pix_ready   = r_pix_ready;
    assign img_flat    = r_img;
    assign nn_reset    = r_nn_reset;
    assign nn_enable   = r_nn_enable;
    assign digit_out   = r_digit_out;
    assign digit_valid = r_digit_valid;
    assign timeout_err = r_timeout_err;
    assign busy        = r_busy;

endmodule

// File: tb/tb_nn_frame_loader.sv
// Directed self-checking bench for nn_frame_loader (RUN_TIMEOUT reduced to 100).
module tb_nn_frame_loader;

    localparam int NPIX = 28 * 28;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [7:0]        pix_data = '0;
    logic              pix_valid = 1'b0;
    logic              pix_sof = 1'b0;
    logic              pix_ready;
    logic [NPIX*8-1:0] img_flat;
    logic              nn_reset;
    logic              nn_enable;
    logic              nn_done = 1'b0;
    logic [7:0]        digit_in = '0;
    logic [7:0]        digit_out;
    logic              digit_valid;
    logic              timeout_err;
    logic              busy;

    int total = 0;
    int bad   = 0;

    nn_frame_loader #(.RUN_TIMEOUT(100)) dut (
        .clk(clk), .reset(reset), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_sof(pix_sof), .pix_ready(pix_ready), .img_flat(img_flat),
        .nn_reset(nn_reset), .nn_enable(nn_enable), .nn_done(nn_done),
        .digit_in(digit_in), .digit_out(digit_out), .digit_valid(digit_valid),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_store(input logic [7:0] p);
`ifdef NN_FRAME_BINARIZE_EN
        return (p >= 8'd128) ? 8'd127 : 8'd0;
`else
        return p >> 1;
`endif
    endfunction

    function automatic logic [7:0] pix_at(input int k);
        return img_flat[k*8 +: 8];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic s);
        pix_data  = d;
        pix_sof   = s;
        pix_valid = 1'b1;
        step();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held low for three edges
        step(); step(); step();
        check("rst_pix_ready", 32'(pix_ready), 1);
        check("rst_nn_reset", 32'(nn_reset), 1);
        check("rst_nn_enable", 32'(nn_enable), 0);
        check("rst_digit_out", 32'(digit_out), 0);
        check("rst_digit_valid", 32'(digit_valid), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_img_zero", 32'(|img_flat), 0);
        reset = 1'b1;
        step();

        // Frame 1: pixel k = k % 256
        for (int k = 0; k < NPIX; k++) send(8'(k % 256), k == 0);
        check("f1_pix_ready_low", 32'(pix_ready), 0);
        check("f1_busy", 32'(busy), 1);
        check("f1_nn_reset_c1", 32'(nn_reset), 1);
        check("f1_byte783", 32'(pix_at(783)), 32'(exp_store(8'd15)));
        check("f1_byte255", 32'(pix_at(255)), 32'(exp_store(8'd255)));
        check("f1_byte0", 32'(pix_at(0)), 32'(exp_store(8'd0)));
        step();
        check("f1_nn_reset_c2", 32'(nn_reset), 1);
        check("f1_nn_enable_c2", 32'(nn_enable), 0);
        step();
        check("f1_nn_reset_run", 32'(nn_reset), 0);
        check("f1_nn_enable_run", 32'(nn_enable), 1);

        // nn_done raised after 50 RUN cycles
        digit_in = 8'd7;
        for (int i = 0; i < 49; i++) step();
        check("run_no_valid_yet", 32'(digit_valid), 0);
        check("run_img_stable", 32'(pix_at(783)), 32'(exp_store(8'd15)));
        nn_done = 1'b1;
        step();
        nn_done = 1'b0;
        check("done_digit_out", 32'(digit_out), 7);
        check("done_digit_valid", 32'(digit_valid), 1);
        check("done_pix_ready", 32'(pix_ready), 1);
        check("done_nn_enable", 32'(nn_enable), 0);
        check("done_busy", 32'(busy), 0);
        step();
        check("done_valid_pulse", 32'(digit_valid), 0);
        check("done_digit_hold", 32'(digit_out), 7);

        // 300 stray pixels, then a resynchronising pix_sof frame
        for (int k = 0; k < 300; k++) send(8'h10, k == 0);
        check("resync_still_load", 32'(pix_ready), 1);
        send(8'hFE, 1'b1);
        for (int k = 0; k < 99; k++) send(8'h20, 1'b0);
        pix_sof = 1'b1;
        step();
        pix_sof = 1'b0;
        for (int k = 0; k < 683; k++) send(8'h20, 1'b0);
        check("resync_783_ready", 32'(pix_ready), 1);
        check("resync_783_nn_reset", 32'(nn_reset), 0);
        send(8'h20, 1'b0);
        check("resync_784_ready", 32'(pix_ready), 0);
        check("resync_784_nn_reset", 32'(nn_reset), 1);
        check("resync_byte0", 32'(pix_at(0)), 32'h7F);
        check("resync_byte299", 32'(pix_at(299)), 32'(exp_store(8'h20)));
        check("resync_byte783", 32'(pix_at(783)), 32'(exp_store(8'h20)));

        // Timeout: nn_done held low for 100 RUN cycles
        step(); step();
        check("to_nn_enable", 32'(nn_enable), 1);
        for (int i = 0; i < 99; i++) step();
        check("to_99_no_valid", 32'(digit_valid), 0);
        check("to_99_enable", 32'(nn_enable), 1);
        step();
        check("to_digit_out", 32'(digit_out), 32'hFF);
        check("to_digit_valid", 32'(digit_valid), 1);
        check("to_err", 32'(timeout_err), 1);
        check("to_pix_ready", 32'(pix_ready), 1);
        step();
        check("to_valid_pulse", 32'(digit_valid), 0);
        send(8'h40, 1'b0);
        check("to_err_sticky", 32'(timeout_err), 1);
        send(8'd127, 1'b1);
        check("to_err_cleared", 32'(timeout_err), 0);

        // Threshold-edge pixels, then reset during RUN
        send(8'd128, 1'b0);
        check("thr_127", 32'(pix_at(0)), 32'(exp_store(8'd127)));
        check("thr_128", 32'(pix_at(1)), 32'(exp_store(8'd128)));
        for (int k = 2; k < NPIX; k++) send(8'h00, 1'b0);
        step(); step();
        check("mid_run_enable", 32'(nn_enable), 1);
        for (int i = 0; i < 5; i++) step();
        reset    = 1'b0;
        nn_done  = 1'b1;
        digit_in = 8'd9;
        step();
        check("abort_nn_enable", 32'(nn_enable), 0);
        check("abort_no_valid", 32'(digit_valid), 0);
        check("abort_digit_out", 32'(digit_out), 0);
        check("abort_pix_ready", 32'(pix_ready), 1);
        check("abort_busy", 32'(busy), 0);
        check("abort_img_zero", 32'(|img_flat), 0);
        reset = 1'b1;
        step();
        check("abort_after_valid", 32'(digit_valid), 0);
        check("abort_after_enable", 32'(nn_enable), 0);
        nn_done = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
